clk_step_ctrl: RTL and testbench

Synthesizable, parametrised successor to the pipeline's fixed toggle-sequence clock source. It generates a clock-enable (`CE`) for the MIPS pipeline registers from the single system clock. It supports free-run, fixed-length burst, single-step and stop, with a programmable prescaler. It also provides a cycle counter, a visible divided clock waveform and a halt input from the pipeline (e.g. on `syscall`/`break`). It sits between the testbench/top level and every pipeline stage register.

---
 rtl/clk_ctrl_pkg.sv | 17 +
 rtl/ce_prescaler.sv | 34 +++
 rtl/clk_step_ctrl.sv | 138 +++++++++++++
 tb/tb_clk_step_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types for the pipeline clock-enable controller: FSM states and MODE encodings.
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_BURST  = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STOP  = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_STEP  = 2'b11;

endpackage

// File: rtl/ce_prescaler.sv
// Prescaler for the pipeline clock-enable: ticks whenever pre_cnt has reached the divisor.
module ce_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] DIV,
    output logic             tick
);

    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_q;

    // Divisor is registered so tick (and hence CE) never depends combinationally on an input.
    // Comparing with >= lets a lowered divisor fire on the next cycle instead of wrapping.
    assign tick = (pre_cnt >= div_q);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt <= '0;
            div_q   <= '0;
        end else begin
            div_q <= DIV;
            if (clear) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_step_ctrl.sv
// Clock-enable source for the MIPS pipeline: free-run, burst, single-step and halt handling
// with a programmable prescaler, CE cycle counter and a visible divided clock.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 8
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [1:0]       MODE,
    input  logic             START,
    input  logic             STEP,
    input  logic             HALT_REQ,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] BURST_LEN,
    output logic             CE,
    output logic             CLK_VIS,
    output logic [CNT_W-1:0] CYCLE_COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             HALTED
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic             tick;
    logic             burst_load;
    logic             burst_last;
    logic             done_next;

    // The prescaler is held at zero outside the busy states, so every entry starts from 0.
    ce_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .clear   (!BUSY),
        .en      (BUSY),
        .DIV     (DIV),
        .tick    (tick)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority inside each state: HALT_REQ, then MODE=stop, then burst completion.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (STEP) begin
                    state_next = ST_STEP;
                end else if (START && MODE == MODE_RUN) begin
                    state_next = ST_RUN;
                end else if (START && MODE == MODE_BURST && BURST_LEN != '0) begin
                    state_next = ST_BURST;
                end
            end
            ST_RUN: begin
                if (HALT_REQ) begin
                    state_next = ST_HALTED;
                end else if (MODE == MODE_STOP) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (HALT_REQ) begin
                    state_next = ST_HALTED;
                end else if (MODE == MODE_STOP) begin
                    state_next = ST_IDLE;
                end else if (CE && remaining == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (HALT_REQ) begin
                    state_next = ST_HALTED;
                end else if (CE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (START) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY       = 1'b0;
        HALTED     = 1'b0;
        CE         = 1'b0;
        burst_load = 1'b0;
        burst_last = 1'b0;
        done_next  = 1'b0;
        BUSY       = (state == ST_RUN) || (state == ST_BURST) || (state == ST_STEP);
        HALTED     = (state == ST_HALTED);
        CE         = BUSY && tick;
        burst_load = (state == ST_IDLE) && !STEP && START && (MODE == MODE_BURST);
        burst_last = (state == ST_BURST) && !HALT_REQ && (MODE != MODE_STOP)
                     && CE && (remaining == CNT_W'(1));
        // A zero-length burst completes at once with a DONE pulse and no CE.
        done_next  = burst_last || (burst_load && BURST_LEN == '0);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            remaining   <= '0;
            CYCLE_COUNT <= '0;
            CLK_VIS     <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            DONE <= done_next;
            if (burst_load) begin
                remaining <= BURST_LEN;
            end else if (state == ST_BURST && HALT_REQ) begin
                remaining <= '0;
            end else if (state == ST_BURST && CE) begin
                remaining <= remaining - CNT_W'(1);
            end
            // A CE coinciding with HALT_REQ has already reached the pipeline, so it still counts.
            if (CE) begin
                CYCLE_COUNT <= CYCLE_COUNT + CNT_W'(1);
                CLK_VIS     <= ~CLK_VIS;
            end
        end
    end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl; a second instance with a 4-bit counter covers counter wrap.
module tb_clk_step_ctrl;

    logic        CLOCK     = 1'b0;
    logic        RESET_N   = 1'b0;
    logic [1:0]  MODE      = 2'b00;
    logic        START     = 1'b0;
    logic        STEP      = 1'b0;
    logic        HALT_REQ  = 1'b0;
    logic [7:0]  DIV       = 8'd0;
    logic [31:0] BURST_LEN = 32'd0;

    logic        CE, CLK_VIS, BUSY, DONE, HALTED;
    logic [31:0] CYCLE_COUNT;
    logic        ce2, vis2, busy2, done2, halted2;
    logic [3:0]  cc2;

    int cyc = 0;
    int ce_q[$];
    int done_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int k, k2, k3;

    clk_step_ctrl #(.CNT_W(32), .DIV_W(8)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .MODE(MODE), .START(START), .STEP(STEP),
        .HALT_REQ(HALT_REQ), .DIV(DIV), .BURST_LEN(BURST_LEN), .CE(CE), .CLK_VIS(CLK_VIS),
        .CYCLE_COUNT(CYCLE_COUNT), .BUSY(BUSY), .DONE(DONE), .HALTED(HALTED)
    );

    clk_step_ctrl #(.CNT_W(4), .DIV_W(8)) dut_w4 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .MODE(MODE), .START(START), .STEP(STEP),
        .HALT_REQ(HALT_REQ), .DIV(DIV), .BURST_LEN(BURST_LEN[3:0]), .CE(ce2), .CLK_VIS(vis2),
        .CYCLE_COUNT(cc2), .BUSY(busy2), .DONE(done2), .HALTED(halted2)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc++;

    always @(negedge CLOCK) begin
        if (CE)   ce_q.push_back(cyc);
        if (DONE) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    // Hold START or STEP for one cycle; k is the cycle in which it was high.
    task automatic pulse(input bit is_step, output int kk);
        kk = cyc;
        if (is_step) STEP = 1'b1;
        else         START = 1'b1;
        @(posedge CLOCK);
        #1;
        STEP  = 1'b0;
        START = 1'b0;
    endtask

    task automatic clr();
        ce_q.delete();
        done_q.delete();
    endtask

    initial begin
        #2;
        check("rst_ce", CE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_halted", HALTED, 0);
        check("rst_vis", CLK_VIS, 0);
        check("rst_count", CYCLE_COUNT, 0);
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        @(posedge CLOCK); #1;

        // Free run, DIV=0, 30 cycles
        MODE = 2'b01; DIV = 8'd0; clr();
        pulse(0, k);
        check("run_busy", BUSY, 1);
        wait_cyc(k + 30);
        MODE = 2'b00;
        wait_cyc(k + 31);
        check("run_ce_n", ce_q.size(), 30);
        check("run_ce_first", ce_q[0], k + 1);
        check("run_ce_last", ce_q[29], k + 30);
        check("run_count", CYCLE_COUNT, 30);
        check("run_count_w4", cc2, 14);
        check("run_vis", CLK_VIS, 0);
        check("run_idle", BUSY, 0);

        // Burst of 4 at DIV=2
        MODE = 2'b10; DIV = 8'd2; BURST_LEN = 32'd4; clr();
        pulse(0, k);
        wait_cyc(k + 4);
        check("wrap_15", cc2, 15);
        wait_cyc(k + 7);
        check("wrap_0", cc2, 0);
        wait_cyc(k + 13);
        check("burst_done_busy", BUSY, 0);
        check("burst_done", DONE, 1);
        wait_cyc(k + 16);
        check("burst_ce_n", ce_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("burst_ce%0d", i), ce_q[i], k + 3 * (i + 1));
        check("burst_done_n", done_q.size(), 1);
        check("burst_done_cyc", done_q[0], k + 13);
        check("burst_count", CYCLE_COUNT, 34);
        check("burst_vis", CLK_VIS, 0);

        // Two single steps at DIV=3
        MODE = 2'b11; DIV = 8'd3; clr();
        pulse(1, k);
        wait_cyc(k + 5);
        check("step1_busy", BUSY, 0);
        wait_cyc(k + 10);
        pulse(1, k2);
        wait_cyc(k2 + 5);
        check("step2_busy", BUSY, 0);
        wait_cyc(k2 + 8);
        check("step_ce_n", ce_q.size(), 2);
        check("step_ce0", ce_q[0], k + 4);
        check("step_ce1", ce_q[1], k2 + 4);
        check("step_count", CYCLE_COUNT, 36);

        // Halt in the middle of a burst of 100
        MODE = 2'b10; DIV = 8'd0; BURST_LEN = 32'd100; clr();
        pulse(0, k);
        wait_cyc(k + 20);
        HALT_REQ = 1'b1;
        wait_cyc(k + 21);
        HALT_REQ = 1'b0;
        check("halt_halted", HALTED, 1);
        check("halt_busy", BUSY, 0);
        check("halt_ce", CE, 0);
        wait_cyc(k + 23);
        pulse(1, k2);
        check("halt_step_ign", HALTED, 1);
        pulse(0, k3);
        check("halt_exit", HALTED, 0);
        check("halt_exit_busy", BUSY, 0);
        wait_cyc(k3 + 5);
        check("halt_busy_after", BUSY, 0);
        check("halt_ce_n", ce_q.size(), 20);
        check("halt_done_n", done_q.size(), 0);
        check("halt_count", CYCLE_COUNT, 56);

        // Lower DIV mid-run
        MODE = 2'b01; DIV = 8'd200; clr();
        pulse(0, k);
        wait_cyc(k + 150);
        DIV = 8'd10;
        wait_cyc(k + 174);
        MODE = 2'b00;
        wait_cyc(k + 176);
        check("div_ce_n", ce_q.size(), 3);
        check("div_ce0", ce_q[0], k + 151);
        check("div_ce1", ce_q[1], k + 162);
        check("div_ce2", ce_q[2], k + 173);
        check("div_count", CYCLE_COUNT, 59);

        // Zero-length burst
        MODE = 2'b10; DIV = 8'd0; BURST_LEN = 32'd0; clr();
        pulse(0, k);
        check("zero_done", DONE, 1);
        check("zero_busy", BUSY, 0);
        wait_cyc(k + 4);
        check("zero_done_n", done_q.size(), 1);
        check("zero_ce_n", ce_q.size(), 0);
        check("zero_count", CYCLE_COUNT, 59);

        // Asynchronous reset mid-burst
        BURST_LEN = 32'd100; clr();
        pulse(0, k);
        wait_cyc(k + 5);
        check("prerst_count", CYCLE_COUNT, 63);
        check("prerst_vis", CLK_VIS, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_ce", CE, 0);
        check("arst_busy", BUSY, 0);
        check("arst_count", CYCLE_COUNT, 0);
        check("arst_vis", CLK_VIS, 0);
        check("arst_done", DONE, 0);
        check("arst_halted", HALTED, 0);
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        k2 = cyc;
        wait_cyc(k2 + 5);
        check("postrst_busy", BUSY, 0);
        check("postrst_done_n", done_q.size(), 0);
        check("postrst_count", CYCLE_COUNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
